// File: rtl/ttfs_encoder_if.sv
// Ingress handshake bundle for the time-to-first-spike encoder.
// The host drives the valid/data pair and the encoder answers with ready.
interface ttfs_encoder_if #(
  parameter int N_CH      = 4,
  parameter int VAL_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_CH*VAL_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ttfs_encoder.sv
// Multichannel time-to-first-spike encoder. An accepted word opens a window
// of 2^VAL_WIDTH cycles. Each channel emits one spike at its latched delay,
// counted from the window start. A one-cycle done pulse follows a window
// that completes normally.
module ttfs_encoder #(
  parameter int N_CH       = 4,
  parameter int VAL_WIDTH  = 5,
  parameter int INVERT     = 0,
  parameter int SILENT_MAX = 0
) (
  input  logic            CLK,
  input  logic            nRST,
  ttfs_encoder_if.slave   in_if,
  input  logic            abort,
  output logic [N_CH-1:0] spikes,
  output logic            window_start,
  output logic            busy,
  output logic            done
);

  localparam logic [VAL_WIDTH-1:0] T_MAX  = {VAL_WIDTH{1'b1}};
  localparam logic [VAL_WIDTH-1:0] T_ZERO = {VAL_WIDTH{1'b0}};
  localparam logic [VAL_WIDTH-1:0] T_ONE  = {{(VAL_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [VAL_WIDTH-1:0] r_t;
  logic [VAL_WIDTH-1:0] w_t_nxt;
  logic                 w_load;
  logic [VAL_WIDTH-1:0] r_delay    [N_CH];
  logic [VAL_WIDTH-1:0] w_delay_in [N_CH];

  // Map each incoming channel value to its spike delay (optionally inverted).
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (INVERT != 0) begin
        w_delay_in[i] = ~in_if.in_data[i*VAL_WIDTH +: VAL_WIDTH];
      end else begin
        w_delay_in[i] = in_if.in_data[i*VAL_WIDTH +: VAL_WIDTH];
      end
    end
  end

  // Next-state logic: accept in IDLE, count through RUN, abort wins over progress.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_if.in_valid) begin
          w_state_nxt = S_RUN;
          w_t_nxt     = T_ZERO;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_t_nxt     = T_ZERO;
        end else if (r_t == T_MAX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_t_nxt = r_t + T_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_t_nxt     = T_ZERO;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_t_nxt     = T_ZERO;
      end
    endcase
  end

  // State and window time registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_t     <= T_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // Per-channel delays, captured only on the accepting edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < N_CH; i++) begin
        r_delay[i] <= T_ZERO;
      end
    end else if (w_load) begin
      for (int i = 0; i < N_CH; i++) begin
        r_delay[i] <= w_delay_in[i];
      end
    end
  end

  // Spike decode from registered state only; a max delay is silent when enabled.
  always_comb begin
    spikes = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if ((r_state == S_RUN) && (r_t == r_delay[i]) &&
          !((SILENT_MAX != 0) && (r_delay[i] == T_MAX))) begin
        spikes[i] = 1'b1;
      end else begin
        spikes[i] = 1'b0;
      end
    end
  end

  // Status outputs derived directly from the state register.
  always_comb begin
    in_if.in_ready = (r_state == S_IDLE);
    busy           = (r_state != S_IDLE);
    done           = (r_state == S_DONE);
    window_start   = (r_state == S_RUN) && (r_t == T_ZERO);
  end

endmodule

// File: tb/tb_ttfs_encoder.sv
// Bench for ttfs_encoder. Three instances share the same stimulus:
// cfg0 plain, cfg1 INVERT=1, cfg2 SILENT_MAX=1. Every output is compared
// cycle by cycle against spike times derived from the channel values.
module tb_ttfs_encoder;

  logic        CLK;
  logic        nRST;
  logic        in_valid;
  logic [19:0] in_data;
  logic        abort;

  logic [3:0] spk  [3];
  logic       ws   [3];
  logic       bsy  [3];
  logic       dn   [3];
  logic       rdy  [3];

  int errors;
  int checks;

  ttfs_encoder_if #(.N_CH(4), .VAL_WIDTH(5)) if_a ();
  ttfs_encoder_if #(.N_CH(4), .VAL_WIDTH(5)) if_b ();
  ttfs_encoder_if #(.N_CH(4), .VAL_WIDTH(5)) if_c ();

  assign if_a.in_valid = in_valid;
  assign if_b.in_valid = in_valid;
  assign if_c.in_valid = in_valid;
  assign if_a.in_data  = in_data;
  assign if_b.in_data  = in_data;
  assign if_c.in_data  = in_data;
  assign rdy[0] = if_a.in_ready;
  assign rdy[1] = if_b.in_ready;
  assign rdy[2] = if_c.in_ready;

  ttfs_encoder #(.N_CH(4), .VAL_WIDTH(5), .INVERT(0), .SILENT_MAX(0)) u_plain (
    .CLK(CLK), .nRST(nRST), .in_if(if_a), .abort(abort),
    .spikes(spk[0]), .window_start(ws[0]), .busy(bsy[0]), .done(dn[0]));

  ttfs_encoder #(.N_CH(4), .VAL_WIDTH(5), .INVERT(1), .SILENT_MAX(0)) u_inv (
    .CLK(CLK), .nRST(nRST), .in_if(if_b), .abort(abort),
    .spikes(spk[1]), .window_start(ws[1]), .busy(bsy[1]), .done(dn[1]));

  ttfs_encoder #(.N_CH(4), .VAL_WIDTH(5), .INVERT(0), .SILENT_MAX(1)) u_sil (
    .CLK(CLK), .nRST(nRST), .in_if(if_c), .abort(abort),
    .spikes(spk[2]), .window_start(ws[2]), .busy(bsy[2]), .done(dn[2]));

  // 10-time-unit clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Spike delay of one channel for a configuration, from the channel value.
  function automatic int delay_of(input int c, input logic [19:0] w, input int ch);
    int v;
    v = int'(w[ch*5 +: 5]);
    return (c == 1) ? (31 - v) : v;
  endfunction

  // Expected spike vector at window offset k.
  function automatic logic [3:0] exp_spk(input int c, input logic [19:0] w, input int k);
    logic [3:0] r;
    r = 4'b0000;
    for (int ch = 0; ch < 4; ch++) begin
      if (delay_of(c, w, ch) == k && !(c == 2 && delay_of(c, w, ch) == 31)) begin
        r[ch] = 1'b1;
      end
    end
    return r;
  endfunction

  // Status word layout: {ready, busy, done, window_start, spikes[3:0]}.
  function automatic logic [7:0] obs_of(input int c);
    return {rdy[c], bsy[c], dn[c], ws[c], spk[c]};
  endfunction

  // Checks one window from its first RUN cycle; abort_at<0 means no abort.
  task automatic body(input logic [19:0] w, input int abort_at, input string tag);
    int cnt [3][4];
    logic [7:0] exp_v;
    for (int c = 0; c < 3; c++) for (int ch = 0; ch < 4; ch++) cnt[c][ch] = 0;
    for (int k = 0; k <= 32; k++) begin
      for (int c = 0; c < 3; c++) begin
        exp_v = {1'b0, 1'b1, (k == 32), (k == 0), (k < 32) ? exp_spk(c, w, k) : 4'b0000};
        checks++;
        if (obs_of(c) !== exp_v) begin
          errors++;
          $display("FAIL %s cfg%0d t=%0d: got %b expected %b", tag, c, k, obs_of(c), exp_v);
        end
        for (int ch = 0; ch < 4; ch++) if (spk[c][ch] === 1'b1) cnt[c][ch]++;
      end
      if (k == abort_at) begin
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        for (int n = 0; n < 4; n++) begin
          for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_of(c) !== 8'b1000_0000) begin
              errors++;
              $display("FAIL %s_after_abort cfg%0d n=%0d: got %b expected %b", tag, c, n, obs_of(c), 8'b1000_0000);
            end
          end
          if (n < 3) begin
            @(posedge CLK); #1;
          end
        end
        return;
      end
      @(posedge CLK); #1;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_of(c) !== 8'b1000_0000) begin
        errors++;
        $display("FAIL %s_idle cfg%0d: got %b expected %b", tag, c, obs_of(c), 8'b1000_0000);
      end
      for (int ch = 0; ch < 4; ch++) begin
        checks++;
        if (cnt[c][ch] != ((c == 2 && delay_of(c, w, ch) == 31) ? 0 : 1)) begin
          errors++;
          $display("FAIL %s_count cfg%0d ch%0d: got %0d spikes expected %0d", tag, c, ch,
                   cnt[c][ch], (c == 2 && delay_of(c, w, ch) == 31) ? 0 : 1);
        end
      end
    end
  endtask

  // Offer one word from IDLE, then check its whole window.
  task automatic test_window(input logic [19:0] w, input string tag);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_data  = 20'($urandom);
    body(w, -1, tag);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_of(c) !== 8'b1000_0000) begin
        errors++;
        $display("FAIL reset cfg%0d: got %b expected %b", c, obs_of(c), 8'b1000_0000);
      end
    end
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Word B waits with in_valid high while A runs; no third window may follow.
  task automatic test_back_to_back(input logic [19:0] a, input logic [19:0] b);
    in_valid = 1'b1;
    in_data  = a;
    @(posedge CLK); #1;
    in_data = b;
    body(a, -1, "b2b_A");
    @(posedge CLK); #1;
    in_valid = 1'b0;
    body(b, -1, "b2b_B");
    for (int n = 0; n < 3; n++) begin
      @(posedge CLK); #1;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs_of(c) !== 8'b1000_0000) begin
          errors++;
          $display("FAIL b2b_no_third cfg%0d: got %b expected %b", c, obs_of(c), 8'b1000_0000);
        end
      end
    end
  endtask

  // Abort at t=10, then abort together with in_valid in IDLE still accepts.
  task automatic test_abort();
    logic [19:0] w;
    logic [19:0] w2;
    w = {5'd9, 5'd20, 5'd12, 5'd2};
    in_valid = 1'b1;
    in_data  = w;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    body(w, 10, "abort");
    w2 = 20'($urandom);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = w2;
    @(posedge CLK); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    body(w2, -1, "abort_idle_accept");
  endtask

  // Reset asserted between edges at t=7 must clear outputs before the next edge.
  task automatic test_async_reset(input logic [19:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_of(c) !== 8'b1000_0000) begin
        errors++;
        $display("FAIL async_reset cfg%0d: got %b expected %b", c, obs_of(c), 8'b1000_0000);
      end
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_of(c) !== 8'b1000_0000) begin
        errors++;
        $display("FAIL after_reset cfg%0d: got %b expected %b", c, obs_of(c), 8'b1000_0000);
      end
    end
    test_window(w, "post_reset");
  endtask

  // Scenario sequence and summary.
  initial begin
    logic [19:0] basic;
    errors   = 0;
    checks   = 0;
    in_valid = 1'b0;
    in_data  = 20'd0;
    abort    = 1'b0;
    basic    = {5'd17, 5'd31, 5'd3, 5'd0};
    test_reset();
    test_window(basic, "basic");
    test_window({5'd16, 5'd16, 5'd31, 5'd0}, "invert_vals");
    test_window({5'd0, 5'd31, 5'd5, 5'd31}, "silent_vals");
    test_back_to_back(20'($urandom), 20'($urandom));
    test_abort();
    for (int r = 0; r < 6; r++) begin
      test_window(20'($urandom), "random");
    end
    test_async_reset(basic);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttfs_encoder.md
Name: ttfs_encoder

Overview:
Multichannel time-to-first-spike encoder. It converts a word of N_CH unsigned values into one spike per channel; each spike's delay from the window start equals that channel's value. It is the transmit end of the spike-time interface whose receive end is the tile's time-to-data decoder. It sits between the host-side data path and the spiking tile inputs, and adds a valid/ready ingress handshake, a window-start marker and an end-of-window pulse.

Parameters:
N_CH, 4, number of spike channels
VAL_WIDTH, 5, bits per channel value; the window length is 2^VAL_WIDTH cycles
INVERT, 0, if 1 the delay is (2^VAL_WIDTH-1) - value, so larger values spike earlier
SILENT_MAX, 0, if 1 a delay equal to 2^VAL_WIDTH-1 produces no spike (encodes "no event")

Ports:
CLK  in  1  clock; all logic is on the rising edge
nRST  in  1  reset, asynchronous and active-low
in_valid  in  1  input word valid
in_ready  out  1  encoder can accept a word
in_data  in  N_CH*VAL_WIDTH  channel i is in_data[i*VAL_WIDTH +: VAL_WIDTH]
abort  in  1  synchronous cancel of the current window
spikes  out  N_CH  one-cycle spike per channel
window_start  out  1  high in the first cycle of the window (t=0)
busy  out  1  high when the state is not IDLE
done  out  1  one-cycle pulse after a window completes normally

Behaviour:
- States: IDLE, RUN, DONE. Time counter t is VAL_WIDTH bits. Latched delays: one VAL_WIDTH register per channel.
- Reset (nRST low, asynchronous):
  - state=IDLE, t=0, delay registers=0.
  - spikes=0, window_start=0, busy=0, done=0, in_ready=1.
- in_ready = (state==IDLE). It is combinational from state.
- Accept: on a rising edge with in_valid && in_ready, latch the delays and move to RUN with t=0.
  - Delay = value if INVERT=0, else the bitwise inverse of the value.
  - in_data is not sampled in any other cycle. The word is never dropped or duplicated, and in_valid held through RUN/DONE is accepted only on return to IDLE.
- RUN: t increments each cycle from 0 to 2^VAL_WIDTH-1 and never wraps.
  - window_start = RUN && t==0.
  - spikes[i] = RUN && t==delay_i, except that with SILENT_MAX=1 a delay equal to max gives no spike.
  - Spike outputs are combinational from registered state only (no path from in_data). Each channel fires exactly once per window, and several channels may fire in the same cycle.
- Window end: on the edge where RUN && t==max, move to DONE. done=1 for exactly one cycle in DONE, then IDLE.
- Latency:
  - Acceptance edge to window_start is 1 cycle.
  - The window lasts 2^VAL_WIDTH cycles.
  - done is asserted 2^VAL_WIDTH cycles after window_start.
  - The next accept is possible on the edge that ends DONE+1, i.e. the first IDLE cycle.
- abort: sampled on rising edges, with priority over normal progression.
  - In RUN or DONE it forces IDLE on the next edge and t=0.
  - No done pulse follows, and spikes become 0 from that edge.
  - In IDLE it has no effect; abort and in_valid together in IDLE means the word is accepted normally.
- Reset mid-window: spikes, busy and window_start drop immediately (asynchronously). No done is emitted and the latched data is discarded.
- Arithmetic: unsigned only; t and the delays are both VAL_WIDTH bits, so no width extension is needed.

Test Plan:
- Basic, N_CH=4, VAL_WIDTH=5, INVERT=0, in_data values {ch0=0, ch1=3, ch2=31, ch3=17}:
  - spikes[0] coincides with window_start.
  - spikes[1], spikes[3] and spikes[2] fire 3, 17 and 31 cycles later.
  - done fires 32 cycles after window_start, busy is high for 33 cycles, and each channel fires exactly once.
- Backpressure: in_valid held high with word A and then word B presented during A's RUN:
  - in_ready is 0 through RUN/DONE.
  - B is accepted on the first IDLE edge and its window_start follows 1 cycle later; no third window starts.
- INVERT=1, values {0,31,16,16}: spikes at t=31, t=0, and t=15 for both ch2 and ch3 in the same cycle.
- SILENT_MAX=1, values {31,5,31,0}: only ch1 (t=5) and ch3 (t=0) spike; done still arrives at t=32.
- Abort at t=10 of a window with values {2,12,20,9}:
  - ch0 and ch3 spike before the abort; ch1 and ch2 never spike.
  - No done pulse; in_ready=1 on the next cycle, and a new word is accepted normally.
- Async reset asserted mid-cycle at t=7: all outputs go to reset values before the next edge. After release, in_ready=1, and a fresh window behaves as in the basic scenario.
